// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: drains words in bursts and presents
// them on a valid/ready stream with a two-entry output buffer and a per-burst last marker.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 6,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_data_out,
  input  logic                   fifo_empty_flag,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [4:0]            blen, blen_nxt;
  logic [4:0]            issued, issued_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic                  inflight, inflight_last;
  logic [1:0]            occ, occ_nxt;
  logic [DATA_WIDTH-1:0] head_data, skid_data;
  logic                  head_last, skid_last;
  logic                  pop, cap;
  logic                  head_from_cap, head_from_skid, skid_from_cap;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign pop     = m_valid & m_ready;
  assign cap     = inflight;
  assign m_valid = (occ != 2'd0);
  assign m_data  = head_data;
  assign m_last  = head_last & m_valid;

  // Never let buffered plus in-flight words exceed the two buffer entries.
  assign fifo_rd_en = (state == BURST) && !fifo_empty_flag && (issued < blen) &&
                      (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  // A captured word lands in the head when the head is (or is becoming) free.
  assign head_from_cap  = cap && ((occ == 2'd0) || (pop && (occ == 2'd1)));
  assign head_from_skid = pop && !head_from_cap;
  assign skid_from_cap  = cap && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop));
  assign occ_nxt        = occ + {1'b0, cap} - {1'b0, pop};

  always_comb begin
    state_nxt  = state;
    blen_nxt   = blen;
    issued_nxt = issued;
    timer_nxt  = timer;
    case (state)
      IDLE: begin
        if (fifo_count >= COUNT_WIDTH'(BURST_LEN)) begin
          blen_nxt   = 5'(BURST_LEN);
          issued_nxt = 5'd0;
          timer_nxt  = '0;
          state_nxt  = BURST;
        end else if ((fifo_count != '0) && (timer == TW'(TIMEOUT - 1))) begin
          blen_nxt   = 5'(fifo_count);
          issued_nxt = 5'd0;
          timer_nxt  = '0;
          state_nxt  = BURST;
        end else if (fifo_count == '0) begin
          timer_nxt = '0;
        end else begin
          timer_nxt = sat_inc(timer);
        end
      end
      BURST: begin
        if (fifo_rd_en) issued_nxt = issued + 5'd1;
        if ((issued == blen) && !inflight) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last word may already have left the buffer before DRAIN was entered.
        if ((pop && m_last) || (occ == 2'd0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      blen          <= 5'd0;
      issued        <= 5'd0;
      timer         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= 2'd0;
      head_data     <= '0;
      head_last     <= 1'b0;
      skid_last     <= 1'b0;
    end else begin
      state         <= state_nxt;
      blen          <= blen_nxt;
      issued        <= issued_nxt;
      timer         <= timer_nxt;
      inflight      <= fifo_rd_en;
      inflight_last <= fifo_rd_en && ((issued + 5'd1) == blen);
      occ           <= occ_nxt;
      if (head_from_cap) begin
        head_data <= fifo_data_out;
        head_last <= inflight_last;
      end else if (head_from_skid) begin
        head_data <= skid_data;
        head_last <= skid_last;
      end
      if (skid_from_cap) skid_last <= inflight_last;
    end
  end

  // Skid data is only ever read behind a valid occupancy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (skid_from_cap) skid_data <= fifo_data_out;
  end

endmodule
